// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared constants for the UART transmit scheduler.
//   state_t        - scheduler FSM states
//   SRC_RF/SRC_ALU - requester indices used by the arbiter grant vector
//   BYTES_*        - bytes per frame for each source
//   DEF_*          - default gap/watchdog parameter values
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_STROBE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_GAP
    } state_t;

    localparam int SRC_RF  = 0;
    localparam int SRC_ALU = 1;

    localparam logic [1:0] BYTES_RF  = 2'd1;
    localparam logic [1:0] BYTES_ALU = 2'd2;

    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request sources and UART_TX handshake of the scheduler.
//   rf_data/rf_vld/rf_ack    - register-file byte request
//   alu_data/alu_vld/alu_ack - 16-bit ALU result request
//   tx_p_data/tx_data_valid  - byte and strobe to UART_TX
//   tx_busy                  - UART_TX Busy
//   sched_busy/err           - scheduler status
// master: the scheduler; slave: the sources and serializer around it.
interface uart_tx_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   rf_data;
    logic                    rf_vld;
    logic                    rf_ack;
    logic [2*DATA_WIDTH-1:0] alu_data;
    logic                    alu_vld;
    logic                    alu_ack;
    logic [DATA_WIDTH-1:0]   tx_p_data;
    logic                    tx_data_valid;
    logic                    tx_busy;
    logic                    sched_busy;
    logic                    err;

    modport master (
        input  rf_data, rf_vld, alu_data, alu_vld, tx_busy,
        output rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy, err
    );

    modport slave (
        output rf_data, rf_vld, alu_data, alu_vld, tx_busy,
        input  rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy, err
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst - clock, async active-high reset
//   en       - grants allowed this cycle
//   req[1:0] - requests (bit 0 = RF, bit 1 = ALU)
//   gnt[1:0] - one-hot combinational grant
// The pointer moves to the loser after every grant, so a lone requester
// is served immediately and contention alternates.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;  // 0: requester 0 favoured on a tie

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= 1'b0;
        else if (|gnt) ptr <= gnt[0];
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates RF (1 byte) and ALU (2 bytes, LSB first)
// results onto a shared UART_TX, sequencing DATA_VALID/Busy per byte with
// an inter-byte gap and a watchdog on Busy rising.
//   clk, rst - clock, async active-high reset
//   bus      - uart_tx_sched_if.master (sources, UART_TX handshake, status)
// All outputs are registered from next-state decode.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    uart_tx_sched_if.master   bus
);
    localparam int DW = DATA_WIDTH;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    // GAP_CYCLES = 0 still spends one cycle in GAP
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);

    state_t          state, state_nx;
    logic [2*DW-1:0] shreg;
    logic [1:0]      byte_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [WW-1:0]   wd_cnt;
    logic [1:0]      gnt;
    logic            gap_done, wd_expired;
    logic            rf_ack_d, alu_ack_d, tx_dv_d, sbusy_d, err_d;
    logic [DW-1:0]   tx_pd_d;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_IDLE),
        .req ({bus.alu_vld, bus.rf_vld}),
        .gnt (gnt)
    );

    assign gap_done   = (gap_cnt >= GAP_LAST);
    // WAIT_HI has lasted TIMEOUT cycles once this is seen
    assign wd_expired = (wd_cnt >= WD_LAST);

    // state + registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            bus.rf_ack        <= 1'b0;
            bus.alu_ack       <= 1'b0;
            bus.tx_data_valid <= 1'b0;
            bus.tx_p_data     <= '0;
            bus.sched_busy    <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            state             <= state_nx;
            bus.rf_ack        <= rf_ack_d;
            bus.alu_ack       <= alu_ack_d;
            bus.tx_data_valid <= tx_dv_d;
            bus.tx_p_data     <= tx_pd_d;
            bus.sched_busy    <= sbusy_d;
            bus.err           <= err_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (|gnt) state_nx = ST_ARM;
            ST_ARM:     if (!bus.tx_busy) state_nx = ST_STROBE;
            ST_STROBE:  state_nx = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (bus.tx_busy)     state_nx = ST_WAIT_LO;
                else if (wd_expired) state_nx = ST_IDLE;
            end
            ST_WAIT_LO: if (!bus.tx_busy) state_nx = ST_GAP;
            ST_GAP:     if (gap_done) state_nx = (byte_cnt != 2'd0) ? ST_ARM : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rf_ack_d  = (state == ST_IDLE) && gnt[SRC_RF];
        alu_ack_d = (state == ST_IDLE) && gnt[SRC_ALU];
        tx_dv_d   = (state_nx == ST_STROBE);
        // byte is held from one strobe to the next
        tx_pd_d   = (state_nx == ST_STROBE) ? shreg[DW-1:0] : bus.tx_p_data;
        sbusy_d   = (state_nx != ST_IDLE);
        err_d     = (state == ST_WAIT_HI) && !bus.tx_busy && wd_expired;
    end

    // payload shift register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= 2'd0;
            gap_cnt  <= '0;
            wd_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt[SRC_RF]) begin
                        shreg    <= {{DW{1'b0}}, bus.rf_data};
                        byte_cnt <= BYTES_RF;
                    end else if (gnt[SRC_ALU]) begin
                        shreg    <= bus.alu_data;
                        byte_cnt <= BYTES_ALU;
                    end
                end
                ST_STROBE: wd_cnt <= '0;
                ST_WAIT_HI: begin
                    if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                    // timeout abandons whatever is left of the frame
                    if (!bus.tx_busy && wd_expired) byte_cnt <= 2'd0;
                end
                ST_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        shreg   <= shreg >> DW;
                        gap_cnt <= '0;
                        if (byte_cnt != 2'd0) byte_cnt <= byte_cnt - 1'b1;
                    end
                end
                ST_GAP: if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench for uart_tx_sched with a frame-level
// reference model (round-robin grant list and expected byte stream).
module tb_uart_tx_sched;
    import uart_tx_sched_pkg::*;

    localparam int DW = 8;
    localparam int G  = 2;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_sched #(.DATA_WIDTH(DW), .GAP_CYCLES(G), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus / model queues
    logic [7:0]  rf_q[$];
    logic [15:0] alu_q[$];
    logic [7:0]  m_rf[$];
    logic [15:0] m_alu[$];
    int          exp_g[$];
    logic [7:0]  exp_b[$];
    bit          fav_alu = 1'b0;

    // observations
    int          got_g[$];
    int          ack_c[$];
    logic [7:0]  got_b[$];
    int          sb_c[$];
    int          fall_q[$];
    int          vld_c[$];
    int          err_n = 0, err_c = 0, idle_c = -1, stab_err = 0;
    bit          prev_sb = 1'b0, hold_arm = 1'b0;
    logic [7:0]  hold_v = 8'h00;

    // UART_TX responder
    int r_dly = 2, r_len = 10, pend = 0, hold = 0;
    bit resp_en = 1'b1, foreign = 1'b0, mbusy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // source agents: hold VLD until ACK, then present the next queued item
    initial begin
        bus.rf_vld = 1'b0; bus.alu_vld = 1'b0;
        bus.rf_data = '0;  bus.alu_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.rf_vld = 1'b0; bus.alu_vld = 1'b0;
                rf_q.delete(); alu_q.delete();
            end else begin
                if (bus.rf_vld && bus.rf_ack) bus.rf_vld = 1'b0;
                else if (!bus.rf_vld && rf_q.size() > 0) begin
                    bus.rf_data = rf_q.pop_front(); bus.rf_vld = 1'b1; vld_c.push_back(cyc);
                end
                if (bus.alu_vld && bus.alu_ack) bus.alu_vld = 1'b0;
                else if (!bus.alu_vld && alu_q.size() > 0) begin
                    bus.alu_data = alu_q.pop_front(); bus.alu_vld = 1'b1; vld_c.push_back(cyc);
                end
            end
        end
    end

    // serializer model: Busy rises r_dly cycles after a strobe, lasts r_len
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0; hold = 0; mbusy = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin mbusy = 1'b1; hold = r_len; end
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) mbusy = 1'b0;
                end
                if (resp_en && bus.tx_data_valid) pend = r_dly;
            end
            if (bus.tx_busy && !(mbusy || foreign)) fall_q.push_back(cyc);
            bus.tx_busy = mbusy || foreign;
        end
    end

    // monitor
    initial forever begin
        @(negedge clk);
        if (rst) hold_arm = 1'b0;
        else if (bus.tx_data_valid) begin
            got_b.push_back(bus.tx_p_data); sb_c.push_back(cyc);
            hold_v = bus.tx_p_data; hold_arm = 1'b1;
        end else if (hold_arm && bus.tx_p_data !== hold_v) stab_err++;
        if (bus.rf_ack)  begin got_g.push_back(SRC_RF);  ack_c.push_back(cyc); end
        if (bus.alu_ack) begin got_g.push_back(SRC_ALU); ack_c.push_back(cyc); end
        if (bus.err) begin err_n++; err_c = cyc; end
        if (prev_sb && !bus.sched_busy) idle_c = cyc;
        prev_sb = bus.sched_busy;
    end

    task automatic clr();
        got_g.delete(); ack_c.delete(); got_b.delete(); sb_c.delete();
        fall_q.delete(); vld_c.delete(); exp_g.delete(); exp_b.delete();
        err_n = 0; idle_c = -1; stab_err = 0;
    endtask

    // present away from the sampling edge so both agents pick up together
    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send_rf(input logic [7:0] b);
        rf_q.push_back(b); m_rf.push_back(b);
    endtask

    task automatic send_alu(input logic [15:0] w);
        alu_q.push_back(w); m_alu.push_back(w);
    endtask

    // frame-level model: tie goes to the favoured source, lone request wins,
    // favour passes to the other source after every grant; drop keeps only
    // the first byte of each frame (watchdog / abort cases)
    task automatic model_frames(input bit drop);
        logic [15:0] w;
        bit pick_alu;
        while (m_rf.size() > 0 || m_alu.size() > 0) begin
            if (m_rf.size() > 0 && m_alu.size() > 0) pick_alu = fav_alu;
            else                                     pick_alu = (m_rf.size() == 0);
            if (pick_alu) begin
                w = m_alu.pop_front();
                exp_g.push_back(SRC_ALU);
                exp_b.push_back(w[7:0]);
                if (!drop) exp_b.push_back(w[15:8]);
            end else begin
                exp_g.push_back(SRC_RF);
                exp_b.push_back(m_rf.pop_front());
            end
            fav_alu = !pick_alu;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        int ok = 0;
        while (n < budget && ok < 2) begin
            @(negedge clk); n++;
            if (rf_q.size() == 0 && alu_q.size() == 0 && !bus.rf_vld && !bus.alu_vld &&
                !bus.sched_busy && pend == 0 && hold == 0 && !foreign) ok++;
            else ok = 0;
        end
        chk({tag, "_done"}, 32'(ok >= 2), 1);
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_ngnt"}, got_g.size(), exp_g.size());
        for (int k = 0; k < got_g.size() && k < exp_g.size(); k++)
            chk($sformatf("%s_gnt%0d", tag, k), got_g[k], exp_g[k]);
        chk({tag, "_nbyte"}, got_b.size(), exp_b.size());
        for (int k = 0; k < got_b.size() && k < exp_b.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), got_b[k], exp_b[k]);
        chk({tag, "_stable"}, stab_err, 0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rf_ack"},  bus.rf_ack, 0);
        chk({tag, "_alu_ack"}, bus.alu_ack, 0);
        chk({tag, "_dv"},      bus.tx_data_valid, 0);
        chk({tag, "_pdata"},   bus.tx_p_data, 0);
        chk({tag, "_sbusy"},   bus.sched_busy, 0);
        chk({tag, "_err"},     bus.err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_outs_zero("rst");
        rst = 1'b0;

        // RF 0xA5, Busy 2 cycles after strobe for 10 cycles
        clr(); r_dly = 2; r_len = 10;
        sync(); send_rf(8'hA5); model_frames(1'b0);
        wait_done("rf", 300);
        cmp_frames("rf");
        if (ack_c.size() > 0 && vld_c.size() > 0) chk("rf_ack_lat", ack_c[0] - vld_c[0], 1);
        if (sb_c.size() > 0 && ack_c.size() > 0)  chk("rf_dv_lat", sb_c[0] - ack_c[0], 1);
        chk("rf_nfall", fall_q.size(), 1);
        if (fall_q.size() > 0) chk("rf_idle", idle_c - fall_q[0], G + 1);
        chk("rf_err", err_n, 0);

        // ALU 0x1234: 0x34 then 0x12 with the gap honoured
        clr();
        sync(); send_alu(16'h1234); model_frames(1'b0);
        wait_done("alu", 400);
        cmp_frames("alu");
        if (sb_c.size() > 1 && fall_q.size() > 0)
            chk("alu_gap", 32'((sb_c[1] - fall_q[0]) >= G + 2), 1);
        if (fall_q.size() > 1) chk("alu_idle", idle_c - fall_q[1], G + 1);
        chk("alu_err", err_n, 0);

        // contention from reset: random frame counts, data and Busy timing
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; fav_alu = 1'b0;
        for (int r = 0; r < 4; r++) begin
            int nrf, nalu;
            clr();
            r_dly = $urandom_range(1, 4); r_len = $urandom_range(1, 8);
            nrf  = (r == 0) ? 2 : $urandom_range(1, 3);
            nalu = (r == 0) ? 2 : $urandom_range(1, 3);
            sync();
            for (int k = 0; k < nrf; k++)  send_rf(8'($urandom));
            for (int k = 0; k < nalu; k++) send_alu(16'($urandom));
            model_frames(1'b0);
            wait_done($sformatf("cont%0d", r), 3000);
            cmp_frames($sformatf("cont%0d", r));
            chk($sformatf("cont%0d_err", r), err_n, 0);
        end

        // no Busy response: watchdog fires, second ALU byte dropped
        clr(); resp_en = 1'b0;
        sync(); send_alu(16'($urandom)); model_frames(1'b1);
        wait_done("wd", 300);
        cmp_frames("wd");
        chk("wd_nerr", err_n, 1);
        if (sb_c.size() > 0) chk("wd_err_time", err_c - sb_c[0], T + 1);
        resp_en = 1'b1;

        // reset while the first ALU byte is in WAIT_LO
        clr(); r_dly = 1; r_len = 20;
        sync(); send_alu(16'($urandom) | 16'h0001); model_frames(1'b1);
        n = 0;
        while (n < 100 && !bus.tx_busy) begin @(negedge clk); n++; end
        chk("rstmid_busy_seen", bus.tx_busy, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_outs_zero("rstmid");
        repeat (2) @(negedge clk);
        cmp_frames("rstmid_pre");
        rst = 1'b0;
        clr(); fav_alu = 1'b0; r_dly = 2; r_len = 6;
        sync(); send_rf(8'($urandom)); send_alu(16'($urandom)); model_frames(1'b0);
        wait_done("rstmid_post", 800);
        cmp_frames("rstmid_post");

        // Busy already high from foreign activity when ARM is entered
        clr(); foreign = 1'b1;
        repeat (2) @(negedge clk);
        sync(); send_rf(8'($urandom)); model_frames(1'b0);
        n = 0;
        while (n < 50 && got_g.size() == 0) begin @(negedge clk); n++; end
        chk("fgn_acked", got_g.size(), 1);
        repeat (5) @(negedge clk);
        chk("fgn_held", sb_c.size(), 0);
        foreign = 1'b0;
        wait_done("fgn", 300);
        cmp_frames("fgn");
        if (sb_c.size() > 0 && fall_q.size() > 0) chk("fgn_dv", sb_c[0] - fall_q[0], 1);
        chk("fgn_err", err_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler sitting between the system controller's two result sources and the shared UART_TX serializer. The two sources are register-file read data (1 byte) and ALU result (16 bits, sent as 2 bytes, LSB first). The block round-robin arbitrates between them and latches the winning payload. It then sequences the UART_TX DATA_VALID/Busy handshake byte by byte, with a configurable inter-byte gap and a watchdog on the Busy response.

## Interface
- DATA_WIDTH, 8, UART byte width; ALU payload is 2*DATA_WIDTH
- GAP_CYCLES, 2, idle cycles inserted after each byte's Busy falls (0 = no gap)
- TIMEOUT, 16, cycles allowed for TX_BUSY to rise after a strobe
---
- CLK  in  1  system clock; one clock domain
- RST  in  1  asynchronous, active-high reset
- RF_DATA  in  DATA_WIDTH  register-file read byte
- RF_VLD  in  1  RF payload valid; held with RF_DATA until RF_ACK
- RF_ACK  out  1  one-cycle pulse: RF payload latched
- ALU_DATA  in  2*DATA_WIDTH  ALU result
- ALU_VLD  in  1  ALU payload valid; held with ALU_DATA until ALU_ACK
- ALU_ACK  out  1  one-cycle pulse: ALU payload latched
- TX_P_DATA  out  DATA_WIDTH  byte to UART_TX P_DATA
- TX_DATA_VALID  out  1  one-cycle strobe to UART_TX DATA_VALID
- TX_BUSY  in  1  UART_TX Busy
- SCHED_BUSY  out  1  high whenever state != IDLE
- ERR  out  1  one-cycle pulse on watchdog timeout

## Operation
- All outputs are registered (Moore). Reset values:
  - RF_ACK, ALU_ACK, TX_DATA_VALID, ERR, SCHED_BUSY = 0
  - TX_P_DATA = 0
  - state = IDLE
  - round-robin pointer favours RF
- States: IDLE, ARM, STROBE, WAIT_HI, WAIT_LO, GAP.
- IDLE:
  - If either VLD is high, grant per round-robin; if only one is high, grant that one.
  - Latch the payload into a 2*DATA_WIDTH shift register.
  - Byte count: RF = 1, ALU = 2.
  - Pulse the matching ACK for the next cycle, flip the pointer to the other source, go to ARM.
  - VLD inputs are ignored in every other state.
- ARM: when TX_BUSY = 0, go to STROBE; otherwise stay.
- STROBE:
  - TX_DATA_VALID = 1 for exactly this one cycle.
  - TX_P_DATA = low byte of the shift register.
  - Clear the watchdog counter; go to WAIT_HI.
- WAIT_HI:
  - On TX_BUSY = 1, go to WAIT_LO.
  - If the counter reaches TIMEOUT first: pulse ERR, drop the remaining bytes, go to IDLE.
- WAIT_LO:
  - On TX_BUSY = 0: shift the register right by DATA_WIDTH, decrement the byte count, go to GAP.
  - No timeout in this state.
- GAP:
  - Count GAP_CYCLES cycles (pass through in 1 cycle if GAP_CYCLES = 0).
  - Then go to ARM if bytes remain, else IDLE.
- TX_P_DATA is held stable from STROBE until the next STROBE.
- Counter widths are $clog2 of the respective parameter + 1; counters saturate and never wrap.
- Reset mid-frame: immediate return to IDLE and all reset values. The partially sent frame is abandoned and its ACK is not reissued.

## Timing
- Request latency, with VLD sampled high in IDLE at edge E0 and TX_BUSY low:
  - ACK is high E0–E1 (state ARM).
  - TX_DATA_VALID is high E1–E2.
- Simultaneous RF_VLD and ALU_VLD after reset: RF is served first, then ALU.
- Under continuous contention, grants strictly alternate.
- A source re-requesting alone is granted immediately, regardless of the pointer.
- Back-to-back frames: IDLE is occupied for at least one cycle between frames.
- ALU frame order: strobe ALU_DATA[7:0], then ALU_DATA[15:8].
- The second strobe occurs no earlier than GAP_CYCLES+2 cycles after TX_BUSY falls.
- TX_BUSY already high at ARM (foreign activity): the strobe waits; no ERR.

## Structure
- Package uart_tx_sched_pkg holds:
  - state encoding constants
  - source IDs (SRC_RF = 0, SRC_ALU = 1)
  - byte-count constants
  - default GAP_CYCLES/TIMEOUT values
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with a registered pointer and update-on-grant.
- The FSM, shift register and counters stay in uart_tx_sched.

## Test plan
- Reset, then RF_VLD = 1 with RF_DATA = 0xA5; model Busy high 2 cycles after the strobe, for 10 cycles.
  - Required: RF_ACK pulse, one TX_DATA_VALID with TX_P_DATA = 0xA5, SCHED_BUSY back to 0 GAP_CYCLES+1 cycles after Busy falls.
- ALU_VLD with ALU_DATA = 0x1234.
  - Required: two strobes, 0x34 then 0x12, each only after TX_BUSY has fallen and the gap has elapsed; one ALU_ACK.
- RF_VLD and ALU_VLD asserted in the same cycle after reset, both re-asserted after their ACKs.
  - Required: grant order RF, ALU, RF, ALU; byte stream matches.
- TX_BUSY held 0 after the strobe.
  - Required: ERR pulse exactly TIMEOUT cycles into WAIT_HI, return to IDLE, no second ALU byte.
- RST asserted during WAIT_LO of the first ALU byte.
  - Required: all outputs 0 asynchronously; next RF request served normally with RF priority.
- TX_BUSY = 1 on entry to ARM for 5 cycles.
  - Required: TX_DATA_VALID held off until the cycle after Busy drops; no ERR.
